// File: rtl/alu_pkg.sv
// Shared definitions for the 16-bit registered ALU.
// Holds the default data width and the 4-bit ALU-control opcode constants
// used by both the combinational core and the registered top.
package alu_pkg;

  localparam int WIDTH = 16;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;
  localparam logic [3:0] ALU_NOR = 4'b1100;

endpackage

// File: rtl/alu_core.sv
// Purely combinational result and flag logic for the ALU.
// Ports:
//   x, y    in   operands (y[3:0] is the shift amount for shift ops)
//   cin     in   carry-in for ADD, borrow-in for SUB
//   opcode  in   4-bit operation select
//   res     out  operation result, truncated to WIDTH bits
//   cout    out  carry-out (ADD) / not-borrow (SUB), 0 for other ops
//   v       out  signed overflow (ADD/SUB), 0 for other ops
//   lt/eq/gt out signed compare of x against y, valid for every opcode
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic [3:0]       opcode,
  output logic [WIDTH-1:0] res,
  output logic             cout,
  output logic             v,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  logic signed [WIDTH-1:0] x_s;
  logic signed [WIDTH-1:0] y_s;
  logic        [WIDTH:0]   add_sum;
  logic        [WIDTH:0]   sub_sum;
  logic        [3:0]       shamt;

  assign x_s   = x;
  assign y_s   = y;
  assign shamt = y[3:0];

  // Subtraction is X + ~Y + !Cin, so the top bit of sub_sum is "no borrow".
  assign add_sum = {1'b0, x} + {1'b0, y}  + {{WIDTH{1'b0}}, cin};
  assign sub_sum = {1'b0, x} + {1'b0, ~y} + {{WIDTH{1'b0}}, ~cin};

  assign lt = (x_s < y_s);
  assign eq = (x == y);
  assign gt = (x_s > y_s);

  always_comb begin
    res  = '0;
    cout = 1'b0;
    v    = 1'b0;
    case (opcode)
      ALU_AND: res = x & y;
      ALU_OR:  res = x | y;
      ALU_ADD: begin
        res  = add_sum[WIDTH-1:0];
        cout = add_sum[WIDTH];
        v    = (x[WIDTH-1] == y[WIDTH-1]) && (add_sum[WIDTH-1] != x[WIDTH-1]);
      end
      ALU_XOR: res = x ^ y;
      ALU_SUB: begin
        res  = sub_sum[WIDTH-1:0];
        cout = sub_sum[WIDTH];
        v    = (x[WIDTH-1] != y[WIDTH-1]) && (sub_sum[WIDTH-1] != x[WIDTH-1]);
      end
      ALU_SLT: res = {{(WIDTH-1){1'b0}}, lt};
      ALU_SLL: res = x << shamt;
      ALU_SRL: res = x >> shamt;
      ALU_SRA: res = x_s >>> shamt;
      ALU_NOR: res = ~(x | y);
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/alu.sv
// 16-bit registered integer ALU for the MIPS-style datapath.
// One output register stage behind the combinational alu_core: results for
// the inputs present at a rising clk edge appear after that edge. A new
// operation may be issued every cycle; there is no handshake.
// Ports:
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-high reset, clears all outputs
//   X, Y    in   operands (Y[3:0] is the shift amount)
//   out     out  registered result
//   Cin     in   carry-in (ADD) / borrow-in (SUB)
//   Cout    out  registered carry-out
//   lt/eq/gt out registered signed compare of X vs Y
//   V       out  registered signed overflow
//   opcode  in   4-bit operation select
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] out,
  input  logic             Cin,
  output logic             Cout,
  output logic             lt,
  output logic             eq,
  output logic             gt,
  output logic             V,
  input  logic [3:0]       opcode
);

  logic [WIDTH-1:0] out_d, out_q;
  logic             cout_d, cout_q;
  logic             v_d, v_q;
  logic             lt_d, lt_q;
  logic             eq_d, eq_q;
  logic             gt_d, gt_q;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .x      (X),
    .y      (Y),
    .cin    (Cin),
    .opcode (opcode),
    .res    (out_d),
    .cout   (cout_d),
    .v      (v_d),
    .lt     (lt_d),
    .eq     (eq_d),
    .gt     (gt_d)
  );

  // Output register stage: reset discards any in-flight result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q  <= '0;
      cout_q <= 1'b0;
      v_q    <= 1'b0;
      lt_q   <= 1'b0;
      eq_q   <= 1'b0;
      gt_q   <= 1'b0;
    end else begin
      out_q  <= out_d;
      cout_q <= cout_d;
      v_q    <= v_d;
      lt_q   <= lt_d;
      eq_q   <= eq_d;
      gt_q   <= gt_d;
    end
  end

  assign out  = out_q;
  assign Cout = cout_q;
  assign V    = v_q;
  assign lt   = lt_q;
  assign eq   = eq_q;
  assign gt   = gt_q;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the registered ALU. Expected values are
// hand-computed constants; flags are compared as {Cout, V, lt, eq, gt}.
module tb_alu;

  logic        clk;
  logic        rst;
  logic [15:0] X;
  logic [15:0] Y;
  logic [15:0] out;
  logic        Cin;
  logic        Cout;
  logic        lt;
  logic        eq;
  logic        gt;
  logic        V;
  logic [3:0]  opcode;

  int n_vec;
  int n_err;

  alu dut (
    .clk    (clk),
    .rst    (rst),
    .X      (X),
    .Y      (Y),
    .out    (out),
    .Cin    (Cin),
    .Cout   (Cout),
    .lt     (lt),
    .eq     (eq),
    .gt     (gt),
    .V      (V),
    .opcode (opcode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] flags();
    return {Cout, V, lt, eq, gt};
  endfunction

  // Drive on the falling edge, capture on the rising edge, sample 1 ns later.
  task automatic run_vec(input string tag, input logic [3:0] op, input logic [15:0] x,
                         input logic [15:0] y, input logic cin,
                         input logic [15:0] e_out, input logic [4:0] e_flags);
    @(negedge clk);
    opcode = op;
    X      = x;
    Y      = y;
    Cin    = cin;
    @(posedge clk);
    #1;
    check_val({tag, ".out"},   {16'h0, out},     {16'h0, e_out});
    check_val({tag, ".flags"}, {27'h0, flags()}, {27'h0, e_flags});
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    rst    = 1'b1;
    opcode = 4'b0010;
    X      = 16'h0005;
    Y      = 16'h0005;
    Cin    = 1'b0;

    // Reset held across edges with a live ADD on the inputs.
    repeat (3) @(posedge clk);
    #1;
    check_val("reset.out",   {16'h0, out},     32'h0);
    check_val("reset.flags", {27'h0, flags()}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    //                 op       X         Y         Cin   out       {C,V,lt,eq,gt}
    run_vec("add",     4'b0010, 16'h0005, 16'h0005, 1'b0, 16'h000A, 5'b00010);
    run_vec("sub",     4'b0110, 16'h0003, 16'h0008, 1'b0, 16'hFFFB, 5'b00100);
    run_vec("and",     4'b0000, 16'h0007, 16'h0006, 1'b0, 16'h0006, 5'b00001);
    run_vec("or",      4'b0001, 16'h0007, 16'h0006, 1'b0, 16'h0007, 5'b00001);
    run_vec("add_ovf", 4'b0010, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 5'b01001);
    run_vec("add_wrap",4'b0010, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 5'b10100);
    run_vec("sra_neg", 4'b1010, 16'h8000, 16'h0004, 1'b0, 16'hF800, 5'b00100);
    run_vec("slt_t",   4'b0111, 16'hFFFF, 16'h0001, 1'b0, 16'h0001, 5'b00100);
    run_vec("xor",     4'b0011, 16'h00F0, 16'h0FF0, 1'b0, 16'h0F00, 5'b00100);
    run_vec("sub_bin", 4'b0110, 16'h0010, 16'h0001, 1'b1, 16'h000E, 5'b10001);
    run_vec("sub_ovf", 4'b0110, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 5'b11100);
    run_vec("add_cin", 4'b0010, 16'h1234, 16'h1111, 1'b1, 16'h2346, 5'b00001);
    run_vec("sll_hiY", 4'b1000, 16'h0001, 16'hFFF3, 1'b1, 16'h0008, 5'b00001);
    run_vec("srl",     4'b1001, 16'h8000, 16'h000F, 1'b0, 16'h0001, 5'b00100);
    run_vec("sll_0",   4'b1000, 16'hABCD, 16'h0010, 1'b0, 16'hABCD, 5'b00100);
    run_vec("nor",     4'b1100, 16'h00FF, 16'h0F00, 1'b0, 16'hF000, 5'b00100);
    run_vec("slt_f",   4'b0111, 16'h0001, 16'hFFFF, 1'b0, 16'h0000, 5'b00001);
    run_vec("illegal", 4'b0100, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 5'b00010);
    run_vec("sra_pos", 4'b1010, 16'h4000, 16'h0002, 1'b0, 16'h1000, 5'b00001);
    run_vec("add_eqc", 4'b0010, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 5'b10010);

    // Mid-operation reset: outputs nonzero, then rst between edges.
    run_vec("pre_rst", 4'b0010, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 5'b01001);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_val("async_rst.out",   {16'h0, out},     32'h0);
    check_val("async_rst.flags", {27'h0, flags()}, 32'h0);
    opcode = 4'b0010;
    X      = 16'h0100;
    Y      = 16'h0200;
    Cin    = 1'b0;
    @(posedge clk);
    #1;
    check_val("rst_held.out",   {16'h0, out},     32'h0);
    check_val("rst_held.flags", {27'h0, flags()}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_val("post_rst.out",   {16'h0, out},     32'h0000_0300);
    check_val("post_rst.flags", {27'h0, flags()}, 32'h0000_0004);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
